// File: rtl/acc_drain_pkg.sv
// Shared constants and FSM state type for the accumulator drain path.
package acc_drain_pkg;
  localparam int          FP16_BIAS = 15;
  localparam logic [15:0] FP16_INF  = 16'h7C00;
  localparam int          FP16_MANT = 10;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;
endpackage

// File: rtl/acc2fp16.sv
// Combinational fixed-point accumulator (acc * 2^(exp-15-FRAC_BITS)) to FP16 converter.
// Build option ACC_DRAIN_RELU_EN: any negative-signed result is forced to +0.
module acc2fp16
  import acc_drain_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 10,
  parameter int EXP_WIDTH = 5
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic [15:0]          fp16
);
  localparam int MW = ACC_WIDTH + 1;
  localparam int PW = $clog2(MW) + 1;

  logic                 sign;
  logic [MW-1:0]        acc_ext;
  logic [MW-1:0]        mag;
  logic [MW-1:0]        norm;
  logic [PW-1:0]        lead_pos;
  logic [PW-1:0]        shamt;
  logic [FP16_MANT-1:0] mant;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [FP16_MANT:0]   mant_rnd;
  logic signed [15:0]   bexp;
  logic [15:0]          result;

  always_comb begin
    sign    = acc[ACC_WIDTH-1];
    acc_ext = {acc[ACC_WIDTH-1], acc};
    mag     = sign ? (~acc_ext + 1'b1) : acc_ext;

    lead_pos = '0;
    for (int i = 0; i < MW; i++) begin
      if (mag[i]) lead_pos = PW'(i);
    end

    // Left-justify so the leading one lands in the top bit; mag==0 leaves it clear.
    shamt    = PW'(MW - 1) - lead_pos;
    norm     = mag << shamt;
    mant     = norm[MW-2 -: FP16_MANT];
    guard    = norm[MW-2-FP16_MANT];
    sticky   = |norm[MW-3-FP16_MANT:0];
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + (FP16_MANT+1)'(round_up);

    // The FP16 bias cancels: biased = p - FRAC_BITS + exp, plus any rounding carry.
    bexp = signed'(16'(lead_pos) + 16'(exp) + 16'(mant_rnd[FP16_MANT]) - 16'(FRAC_BITS));

    if (!norm[MW-1])
      result = 16'h0000;
    else if (bexp >= 16'sd31)
      result = {sign, FP16_INF[14:0]};
    else if (bexp <= 16'sd0)
      result = {sign, 15'h0000};
    else
      result = {sign, bexp[4:0], mant_rnd[FP16_MANT-1:0]};

`ifdef ACC_DRAIN_RELU_EN
    fp16 = result[15] ? 16'h0000 : result;
`else
    fp16 = result;
`endif
  end
endmodule

// File: rtl/acc_drain.sv
// Captures an N*N accumulator tile on done and streams FP16 results in row-major order.
// Build option ACC_DRAIN_RELU_EN (in acc2fp16) clamps negative results to zero.
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int N         = 2,
  parameter int FRAC_BITS = 10,
  parameter int EXP_WIDTH = 5,
  localparam int NE       = N * N,
  localparam int IW       = (NE > 1) ? $clog2(NE) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done,
  input  logic [NE*ACC_WIDTH-1:0] acc_in,
  input  logic [NE*EXP_WIDTH-1:0] exp_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_data,
  output logic [IW-1:0]           out_idx,
  output logic                    busy,
  output logic                    drain_done,
  output logic                    overrun
);
  localparam logic [IW-1:0] LAST = IW'(NE - 1);

  state_t               state_reg;
  logic [IW-1:0]        idx_reg;
  logic [IW-1:0]        conv_sel;
  logic                 done_low_reg;
  logic [ACC_WIDTH-1:0] acc_bank_reg [NE];
  logic [EXP_WIDTH-1:0] exp_bank_reg [NE];
  logic [ACC_WIDTH-1:0] acc_slice    [NE];
  logic [EXP_WIDTH-1:0] exp_slice    [NE];
  logic [15:0]          conv_data;

  generate
    for (genvar gi = 0; gi < NE; gi++) begin : g_unpack
      assign acc_slice[gi] = acc_in[gi*ACC_WIDTH +: ACC_WIDTH];
      assign exp_slice[gi] = exp_in[gi*EXP_WIDTH +: EXP_WIDTH];
    end
  endgenerate

  // In EMIT the converter already looks at the next entry so an accept can load it directly.
  assign conv_sel = (state_reg == EMIT && idx_reg != LAST) ? IW'(idx_reg + 1'b1) : idx_reg;

  acc2fp16 #(
    .ACC_WIDTH(ACC_WIDTH),
    .FRAC_BITS(FRAC_BITS),
    .EXP_WIDTH(EXP_WIDTH)
  ) u_conv (
    .acc (acc_bank_reg[conv_sel]),
    .exp (exp_bank_reg[conv_sel]),
    .fp16(conv_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      done_low_reg <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_idx      <= '0;
      busy         <= 1'b0;
      drain_done   <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NE; i++) begin
        acc_bank_reg[i] <= '0;
        exp_bank_reg[i] <= '0;
      end
    end else begin
      drain_done <= 1'b0;
      // A fresh done only counts as a new tile once the capturing done has dropped.
      if (busy && !done) done_low_reg <= 1'b1;
      if (busy && done && done_low_reg) overrun <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (done) begin
            for (int i = 0; i < NE; i++) begin
              acc_bank_reg[i] <= acc_slice[i];
              exp_bank_reg[i] <= exp_slice[i];
            end
            idx_reg      <= '0;
            busy         <= 1'b1;
            done_low_reg <= 1'b0;
            state_reg    <= CONV;
          end
        end
        CONV: begin
          out_data  <= conv_data;
          out_idx   <= idx_reg;
          out_valid <= 1'b1;
          state_reg <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (idx_reg == LAST) begin
              out_valid  <= 1'b0;
              busy       <= 1'b0;
              drain_done <= 1'b1;
              state_reg  <= IDLE;
            end else begin
              out_data <= conv_data;
              out_idx  <= IW'(idx_reg + 1'b1);
              idx_reg  <= IW'(idx_reg + 1'b1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_drain.sv
// Scoreboard bench for acc_drain: directed tiles, backpressure, protocol cases and random tiles.
module tb_acc_drain;
  localparam int ACC_WIDTH = 32;
  localparam int N         = 2;
  localparam int FRAC_BITS = 10;
  localparam int EXP_WIDTH = 5;
  localparam int NE        = N * N;
  localparam int IW        = (NE > 1) ? $clog2(NE) : 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    done = 1'b0;
  logic [NE*ACC_WIDTH-1:0] acc_in = '0;
  logic [NE*EXP_WIDTH-1:0] exp_in = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [15:0]             out_data;
  logic [IW-1:0]           out_idx;
  logic                    busy;
  logic                    drain_done;
  logic                    overrun;

  acc_drain #(
    .ACC_WIDTH(ACC_WIDTH), .N(N), .FRAC_BITS(FRAC_BITS), .EXP_WIDTH(EXP_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .done(done), .acc_in(acc_in), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .drain_done(drain_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   data;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          ready_mode = 0;
  int          stall_cnt  = 0;
  int          cyc = 0;
  logic [31:0] ta [NE];
  logic [4:0]  te [NE];
  logic [15:0] tx [NE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic logic [15:0] relu_fix(input logic [15:0] v);
`ifdef ACC_DRAIN_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  // Reference: real-valued acc*2^(exp-25), normalised by search, RNE on the scaled fraction.
  function automatic logic [15:0] ref_fp16(input logic [31:0] a, input logic [4:0] e);
    longint sa = longint'($signed(a));
    logic   s  = (sa < 0);
    longint m  = s ? -sa : sa;
    real    v, f, rem;
    int     ue, fl, be;
    logic [15:0] r;
    if (m == 0) return 16'h0000;
    v  = real'(m) * pow2(int'(e) - 15 - FRAC_BITS);
    ue = 0;
    while (v >= pow2(ue + 1)) ue++;
    while (v < pow2(ue)) ue--;
    f   = (v / pow2(ue) - 1.0) * 1024.0;
    fl  = $rtoi(f);
    rem = f - real'(fl);
    if (rem > 0.5 || (rem == 0.5 && (fl % 2) == 1)) fl++;
    if (fl == 1024) begin fl = 0; ue++; end
    be = ue + 15;
    if (be >= 31)     r = {s, 15'h7C00};
    else if (be <= 0) r = {s, 15'h0000};
    else              r = {s, 5'(be), 10'(fl)};
    return relu_fix(r);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready generator: always, toggling, random, or a 3-cycle stall on idx 1.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && out_idx == 1 && stall_cnt < 3) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else out_ready = 1'b1;
      end
    endcase
  end

  // Monitor: compares each accepted result with the scoreboard and checks holds under stall.
  initial begin
    logic          hold_pending = 1'b0;
    logic [15:0]   hold_data = '0;
    logic [IW-1:0] hold_idx = '0;
    int            last_acc_cyc = 0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        check("drain_done_idle", 32'(drain_done), 32'd0);
        if (hold_pending) begin
          check("hold_data", 32'(out_data), 32'(hold_data));
          check("hold_idx", 32'(out_idx), 32'(hold_idx));
        end
        if (out_ready) begin
          hold_pending = 1'b0;
          if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'(sb_q.size() == 0), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("data", 32'(out_data), 32'(e.data));
            check("idx", 32'(out_idx), 32'(e.idx));
            if (ready_mode == 0 && e.idx != 0) check("b2b_gap", 32'(cyc - last_acc_cyc), 32'd1);
            last_acc_cyc = cyc;
            $display("accept idx=%0d data=%h expected=%h", out_idx, out_data, e.data);
            if (e.idx == IW'(NE - 1)) begin
              @(posedge clk);
              #1;
              check("drain_done_pulse", 32'(drain_done), 32'd1);
              check("valid_after_last", 32'(out_valid), 32'd0);
              check("busy_after_last", 32'(busy), 32'd0);
            end
          end
        end else begin
          hold_pending = 1'b1;
          hold_data    = out_data;
          hold_idx     = out_idx;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic drive_tile(input logic [31:0] a [NE], input logic [4:0] e [NE],
                            input logic [15:0] x [NE]);
    exp_t item;
    wait_idle(500);
    @(negedge clk);
    for (int i = 0; i < NE; i++) begin
      acc_in[i*ACC_WIDTH +: ACC_WIDTH] = a[i];
      exp_in[i*EXP_WIDTH +: EXP_WIDTH] = e[i];
      item.data = x[i];
      item.idx  = IW'(i);
      sb_q.push_back(item);
    end
    done = 1'b1;
    @(posedge clk);
    #1;
    check("lat_conv_valid", 32'(out_valid), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    done = 1'b0;
    @(posedge clk);
    #1;
    check("lat_first_valid", 32'(out_valid), 32'd1);
    check("lat_first_idx", 32'(out_idx), 32'd0);
  endtask

  task automatic load_nominal();
    ta[0] = 32'hFFFFBC00; ta[1] = 32'hFFFF9000; ta[2] = 32'hFFFFAC00; ta[3] = 32'hFFFFAC00;
    tx[0] = relu_fix(16'hCC40); tx[1] = relu_fix(16'hCF00);
    tx[2] = relu_fix(16'hCD40); tx[3] = relu_fix(16'hCD40);
    for (int i = 0; i < NE; i++) te[i] = 5'd15;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drain_done", 32'(drain_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Nominal tile, continuous ready.
    ready_mode = 0;
    load_nominal();
    drive_tile(ta, te, tx);

    // 3-cycle stall on idx 1, then toggling ready.
    wait_idle(500);
    stall_cnt  = 0;
    ready_mode = 3;
    drive_tile(ta, te, tx);
    wait_idle(500);
    ready_mode = 1;
    drive_tile(ta, te, tx);

    // Arithmetic edge cases.
    wait_idle(500);
    ready_mode = 0;
    ta[0] = 32'h00000000; te[0] = 5'd15; tx[0] = relu_fix(16'h0000);
    ta[1] = 32'h00000400; te[1] = 5'd15; tx[1] = relu_fix(16'h3C00);
    ta[2] = 32'h00000C01; te[2] = 5'd15; tx[2] = relu_fix(16'h4200);
    ta[3] = 32'h7FFFFFFF; te[3] = 5'd30; tx[3] = relu_fix(16'h7C00);
    drive_tile(ta, te, tx);
    ta[0] = 32'h00000001; te[0] = 5'd1;  tx[0] = relu_fix(16'h0000);
    ta[1] = 32'h80000000; te[1] = 5'd15; tx[1] = ref_fp16(ta[1], te[1]);
    ta[2] = 32'hFFFFFFFF; te[2] = 5'd0;  tx[2] = ref_fp16(ta[2], te[2]);
    ta[3] = 32'h00000FFF; te[3] = 5'd15; tx[3] = ref_fp16(ta[3], te[3]);
    drive_tile(ta, te, tx);

    // done re-pulsed mid-drain: overrun sets, stream unaffected.
    wait_idle(500);
    ready_mode = 1;
    load_nominal();
    drive_tile(ta, te, tx);
    check("overrun_before", 32'(overrun), 32'd0);
    @(negedge clk);
    acc_in = {$urandom, $urandom, $urandom, $urandom};
    done   = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(posedge clk);
    #1;
    check("overrun_set", 32'(overrun), 32'd1);
    wait_idle(500);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while idx 1 is presented.
    ready_mode = 0;
    load_nominal();
    drive_tile(ta, te, tx);
    @(posedge clk);
    #3;
    check("pre_rst_idx", 32'(out_idx), 32'd1);
    rst = 1'b0;
    #1;
    sb_q.delete();
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_data", 32'(out_data), 32'd0);
    check("mrst_idx", 32'(out_idx), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ta[0] = 32'h00000400; te[0] = 5'd15; tx[0] = relu_fix(16'h3C00);
    drive_tile(ta, te, tx);

    // Random tiles under random backpressure.
    for (int t = 0; t < 15; t++) begin
      wait_idle(500);
      ready_mode = 2;
      for (int i = 0; i < NE; i++) begin
        case ($urandom_range(0, 3))
          0: ta[i] = $urandom;
          1: ta[i] = $urandom_range(0, 1) ? 32'($urandom_range(0, 8191))
                                          : -32'($urandom_range(0, 8191));
          2: ta[i] = 32'h0;
          default: ta[i] = $urandom_range(0, 1) ? 32'h80000000 : 32'h7FFFFFFF;
        endcase
        te[i] = 5'($urandom_range(0, 31));
        tx[i] = ref_fp16(ta[i], te[i]);
      end
      drive_tile(ta, te, tx);
    end

    wait_idle(500);
    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
